alu_seq: RTL and testbench

//  Parametrised multi-cycle integer ALU for the EX stage. Single-cycle ops (add/sub/logic/cmp)

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_iter_muldiv.sv | 55 +++++
 rtl/alu_seq.sv | 204 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcode/func constants, flag bit positions, FSM states, decoded op kinds.
package alu_pkg;
   localparam logic [2:0] ALU_RTYPE = 3'b010;
   localparam logic [2:0] OPC_ADDI  = 3'b000;
   localparam logic [2:0] OPC_SUBI  = 3'b001;
   localparam logic [2:0] OPC_ANDI  = 3'b011;
   localparam logic [2:0] OPC_ORI   = 3'b100;

   localparam logic [4:0] F_ADD = 5'd0;
   localparam logic [4:0] F_SUB = 5'd2;
   localparam logic [4:0] F_MUL = 5'd4;
   localparam logic [4:0] F_DIV = 5'd5;
   localparam logic [4:0] F_AND = 5'd6;
   localparam logic [4:0] F_OR  = 5'd8;
   localparam logic [4:0] F_NOT = 5'd10;
   localparam logic [4:0] F_CMP = 5'd11;

   localparam int FLAG_OVF  = 2;
   localparam int FLAG_NEG  = 1;
   localparam int FLAG_ZERO = 0;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_CMP, OP_ILL
   } op_e;
endpackage

// File: rtl/alu_iter_muldiv.sv
// One-bit-per-step unsigned shift-add multiplier / restoring divider sharing a {hi,lo} accumulator.
// o_hi/o_lo are the values the accumulator takes on the current step, so the owner can capture the last step directly.
module alu_iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH:0]   w_madd;
   logic [WIDTH:0]   w_rem;
   logic [WIDTH-1:0] w_trial;
   logic             w_fits;

   always_comb begin
      o_hi    = '0;
      o_lo    = '0;
      w_madd  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_rem   = {r_hi, r_lo[WIDTH-1]};
      // remainder stays below the divisor, so the low WIDTH bits of the difference are exact
      w_trial = w_rem[WIDTH-1:0] - r_b;
      w_fits  = (w_rem >= {1'b0, r_b});
      if (i_div) begin
         o_hi = w_fits ? w_trial : w_rem[WIDTH-1:0];
         o_lo = {r_lo[WIDTH-2:0], w_fits};
      end else begin
         o_hi = w_madd[WIDTH:1];
         o_lo = {w_madd[0], r_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi <= '0;
         r_lo <= '0;
         r_b  <= '0;
      end else if (i_load) begin
         r_hi <= '0;
         r_lo <= i_a;
         r_b  <= i_b;
      end else if (i_step) begin
         r_hi <= o_hi;
         r_lo <= o_lo;
      end
   end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: single-cycle ops valid one cycle after accept, MUL/DIV after WIDTH cycles.
// ready drops for the whole MUL/DIV run; start while not ready is dropped, never queued.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int FUNC_W = 5,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CTRL_W-1:0] alu_control,
   input  logic [FUNC_W-1:0] func,
   input  logic [WIDTH-1:0]  data_a,
   input  logic [WIDTH-1:0]  data_b,
   output logic              ready,
   output logic              valid,
   output logic [WIDTH-1:0]  result,
   output logic [WIDTH-1:0]  result_hi,
   output logic [2:0]        flag
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           r_state;
   state_e           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_valid;
   logic             r_is_div;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_result_hi;
   logic [2:0]       r_flag;

   op_e              w_op;
   logic             w_accept;
   logic             w_long;
   logic             w_load;
   logic             w_step;
   logic             w_fin;
   logic             w_div0;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_dif;
   logic             w_sum_ovf;
   logic             w_dif_ovf;
   logic [WIDTH-1:0] w_logic;
   logic [WIDTH-1:0] w_md_hi;
   logic [WIDTH-1:0] w_md_lo;

   function automatic logic [2:0] mk_flag(input logic ovf, input logic [WIDTH-1:0] val);
      logic [2:0] f;
      f            = 3'b000;
      f[FLAG_OVF]  = ovf;
      f[FLAG_NEG]  = val[WIDTH-1];
      f[FLAG_ZERO] = (val == '0);
      return f;
   endfunction

   always_comb begin
      w_op = OP_ILL;
      if (alu_control == CTRL_W'(ALU_RTYPE)) begin
         case (func)
            FUNC_W'(F_ADD): w_op = OP_ADD;
            FUNC_W'(F_SUB): w_op = OP_SUB;
            FUNC_W'(F_MUL): w_op = OP_MUL;
            FUNC_W'(F_DIV): w_op = OP_DIV;
            FUNC_W'(F_AND): w_op = OP_AND;
            FUNC_W'(F_OR):  w_op = OP_OR;
            FUNC_W'(F_NOT): w_op = OP_NOT;
            FUNC_W'(F_CMP): w_op = OP_CMP;
            default:        w_op = OP_ILL;
         endcase
      end else begin
         case (alu_control)
            CTRL_W'(OPC_ADDI): w_op = OP_ADD;
            CTRL_W'(OPC_SUBI): w_op = OP_SUB;
            CTRL_W'(OPC_ANDI): w_op = OP_AND;
            CTRL_W'(OPC_ORI):  w_op = OP_OR;
            default:           w_op = OP_ILL;
         endcase
      end
   end

   // sign-extended by one bit so signed overflow shows as a mismatch of the top two bits
   assign w_sum     = {data_a[WIDTH-1], data_a} + {data_b[WIDTH-1], data_b};
   assign w_dif     = {data_a[WIDTH-1], data_a} - {data_b[WIDTH-1], data_b};
   assign w_sum_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
   assign w_dif_ovf = w_dif[WIDTH] ^ w_dif[WIDTH-1];
   assign w_div0    = (data_b == '0);
   assign w_long    = (w_op == OP_MUL) || ((w_op == OP_DIV) && !w_div0);

   always_comb begin
      w_logic = '0;
      case (w_op)
         OP_AND:  w_logic = data_a & data_b;
         OP_OR:   w_logic = data_a | data_b;
         OP_NOT:  w_logic = ~data_a;
         default: w_logic = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_fin       = 1'b0;
      case (r_state)
         IDLE: begin
            w_accept = start;
            if (start && w_long) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_fin       = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                r_cnt <= '0;
      else if (w_load || w_fin) r_cnt <= '0;
      else if (w_step)          r_cnt <= r_cnt + CNT_W'(1);
   end

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_step (w_step),
      .i_div  (r_is_div),
      .i_a    (data_a),
      .i_b    (data_b),
      .o_hi   (w_md_hi),
      .o_lo   (w_md_lo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid     <= 1'b0;
         r_is_div    <= 1'b0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_flag      <= 3'b000;
      end else begin
         r_valid <= 1'b0;
         if (w_load) r_is_div <= (w_op == OP_DIV);
         if (w_accept && !w_long) begin
            r_valid <= 1'b1;
            case (w_op)
               OP_ADD: begin
                  r_result    <= w_sum[WIDTH-1:0];
                  r_result_hi <= '0;
                  r_flag      <= mk_flag(w_sum_ovf, w_sum[WIDTH-1:0]);
               end
               OP_SUB: begin
                  r_result    <= w_dif[WIDTH-1:0];
                  r_result_hi <= '0;
                  r_flag      <= mk_flag(w_dif_ovf, w_dif[WIDTH-1:0]);
               end
               OP_AND, OP_OR, OP_NOT: begin
                  r_result    <= w_logic;
                  r_result_hi <= '0;
                  r_flag      <= mk_flag(1'b0, w_logic);
               end
               OP_CMP: r_flag <= mk_flag(w_dif_ovf, w_dif[WIDTH-1:0]);
               OP_DIV: begin
                  // only the divide-by-zero case reaches here; it never enters RUN
                  r_result    <= '1;
                  r_result_hi <= data_a;
                  r_flag      <= mk_flag(1'b1, '1);
               end
               default: begin
                  r_result    <= '0;
                  r_result_hi <= '0;
               end
            endcase
         end
         if (w_fin) begin
            r_valid     <= 1'b1;
            r_result    <= w_md_lo;
            r_result_hi <= w_md_hi;
            r_flag      <= mk_flag(!r_is_div && (w_md_hi != '0), w_md_lo);
         end
      end
   end

   assign ready     = (r_state == IDLE);
   assign valid     = r_valid;
   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign flag      = r_flag;
endmodule

// File: tb/tb_alu_seq.sv
// Directed vector table for single-cycle ops plus hand-written MUL/DIV, reset and handshake sequences.
module tb_alu_seq;
   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  alu_control;
   logic [4:0]  func;
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic        ready;
   logic        valid;
   logic [31:0] result;
   logic [31:0] result_hi;
   logic [2:0]  flag;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0]  ctrl;
      logic [4:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] hi;
      logic [2:0]  flg;
   } vec_t;

   vec_t tbl[16];

   alu_seq #(.WIDTH(32), .FUNC_W(5), .CTRL_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .alu_control (alu_control),
      .func        (func),
      .data_a      (data_a),
      .data_b      (data_b),
      .ready       (ready),
      .valid       (valid),
      .result      (result),
      .result_hi   (result_hi),
      .flag        (flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic launch(input logic [2:0] c, input logic [4:0] f, input logic [31:0] a,
                         input logic [31:0] b);
      alu_control = c;
      func        = f;
      data_a      = a;
      data_b      = b;
      start       = 1'b1;
   endtask

   // Waits for valid after a launch; counts cycles with ready low before it arrives.
   task automatic wait_result(input string nm, input logic [31:0] e_res, input logic [31:0] e_hi,
                              input logic [2:0] e_flg, input int e_wait, input bit mid_pulse);
      int  lowc = 0;
      bit  got  = 1'b0;
      for (int i = 1; i <= 100 && !got; i++) begin
         @(posedge clk); #1;
         if (i == 1) start = 1'b0;
         if (valid) got = 1'b1;
         else if (!ready) lowc++;
         if (mid_pulse && i == 10) launch(3'b010, 5'd0, 32'h0, 32'h0);
         if (mid_pulse && i == 11) start = 1'b0;
      end
      chk({nm, "_got_valid"}, 32'(got), 32'd1);
      chk({nm, "_ready_low"}, 32'(lowc), 32'(e_wait));
      chk({nm, "_result"}, result, e_res);
      chk({nm, "_result_hi"}, result_hi, e_hi);
      chk({nm, "_flag"}, 32'(flag), 32'(e_flg));
   endtask

   initial begin
      int nv;
      tbl[0]  = '{3'b010, 5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 3'b110};
      tbl[1]  = '{3'b001, 5'd0,  32'h00000005, 32'h00000005, 32'h00000000, 32'h0, 3'b001};
      tbl[2]  = '{3'b010, 5'd11, 32'h00000003, 32'h00000007, 32'h00000000, 32'h0, 3'b010};
      tbl[3]  = '{3'b000, 5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 3'b001};
      tbl[4]  = '{3'b010, 5'd2,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 3'b100};
      tbl[5]  = '{3'b010, 5'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 3'b010};
      tbl[6]  = '{3'b100, 5'd0,  32'h0000000F, 32'h000000F0, 32'h000000FF, 32'h0, 3'b000};
      tbl[7]  = '{3'b010, 5'd10, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 32'h0, 3'b010};
      tbl[8]  = '{3'b011, 5'd0,  32'h12345678, 32'h00000000, 32'h00000000, 32'h0, 3'b001};
      tbl[9]  = '{3'b010, 5'd8,  32'h00000001, 32'h00000002, 32'h00000003, 32'h0, 3'b000};
      tbl[10] = '{3'b010, 5'd0,  32'h00000005, 32'h00000006, 32'h0000000B, 32'h0, 3'b000};
      tbl[11] = '{3'b010, 5'd11, 32'h00000001, 32'h00000002, 32'h0000000B, 32'h0, 3'b010};
      tbl[12] = '{3'b010, 5'd11, 32'h80000000, 32'h00000001, 32'h0000000B, 32'h0, 3'b100};
      tbl[13] = '{3'b010, 5'd0,  32'hFFFFFFF0, 32'h00000005, 32'hFFFFFFF5, 32'h0, 3'b010};
      tbl[14] = '{3'b010, 5'd31, 32'h00000009, 32'h00000009, 32'h00000000, 32'h0, 3'b010};
      tbl[15] = '{3'b111, 5'd0,  32'h00000009, 32'h00000009, 32'h00000000, 32'h0, 3'b010};

      reset = 1'b1; start = 1'b0; alu_control = 3'b0; func = 5'd0; data_a = '0; data_b = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_result_hi", result_hi, 32'h0);
      chk("rst_flag", 32'(flag), 32'd0);

      for (int i = 0; i < 16; i++) begin
         launch(tbl[i].ctrl, tbl[i].fn, tbl[i].a, tbl[i].b);
         @(posedge clk); #1;
         start = 1'b0;
         chk($sformatf("v%0d_valid", i), 32'(valid), 32'd1);
         chk($sformatf("v%0d_result", i), result, tbl[i].res);
         chk($sformatf("v%0d_result_hi", i), result_hi, tbl[i].hi);
         chk($sformatf("v%0d_flag", i), 32'(flag), 32'(tbl[i].flg));
      end
      @(posedge clk); #1;
      chk("valid_drops", 32'(valid), 32'd0);

      launch(3'b010, 5'd4, 32'hFFFFFFFF, 32'h00000002);
      wait_result("mul_ff_x2", 32'hFFFFFFFE, 32'h1, 3'b110, 32, 1'b1);
      @(posedge clk); #1;
      chk("mul_pulse_once", 32'(valid), 32'd0);

      launch(3'b010, 5'd0, 32'h1, 32'h1);
      wait_result("add_after_mul", 32'h2, 32'h0, 3'b000, 0, 1'b0);
      launch(3'b010, 5'd4, 32'h00010000, 32'h00010000);
      wait_result("mul_2p32", 32'h0, 32'h1, 3'b101, 32, 1'b0);

      launch(3'b010, 5'd5, 32'd100, 32'd7);
      wait_result("div_100_7", 32'd14, 32'd2, 3'b000, 32, 1'b0);
      launch(3'b010, 5'd5, 32'hFFFFFFFF, 32'h10);
      wait_result("div_b2b", 32'h0FFFFFFF, 32'hF, 3'b000, 32, 1'b0);
      launch(3'b010, 5'd5, 32'd9, 32'd0);
      wait_result("div_by0", 32'hFFFFFFFF, 32'd9, 3'b110, 0, 1'b0);

      launch(3'b010, 5'd4, 32'd3, 32'd5);
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midrun_rst_ready", 32'(ready), 32'd1);
      chk("midrun_rst_valid", 32'(valid), 32'd0);
      chk("midrun_rst_result", result, 32'h0);
      chk("midrun_rst_result_hi", result_hi, 32'h0);
      chk("midrun_rst_flag", 32'(flag), 32'd0);
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (valid) nv++;
      end
      chk("midrun_rst_no_valid", 32'(nv), 32'd0);

      launch(3'b010, 5'd0, 32'd5, 32'd6);
      wait_result("add_pre_rst", 32'hB, 32'h0, 3'b000, 0, 1'b0);
      launch(3'b010, 5'd0, 32'd1, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      chk("rst_start_valid", 32'(valid), 32'd0);
      chk("rst_start_result", result, 32'h0);
      @(posedge clk); #1;
      chk("rst_start_dropped", 32'(valid), 32'd0);
      chk("rst_start_ready", 32'(ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
